// File: rtl/riscv_pkg.sv
// Shared RV32I control-flow constants and the 2-bit predictor counter helper.
package riscv_pkg;
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] PCSRC_NONE   = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;
  localparam logic [1:0] PCSRC_PC4    = 2'b11;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] ctrNext(input logic [1:0] c, input logic up);
    if (up) return (c == ST) ? ST : c + 2'd1;
    else    return (c == SNT) ? SNT : c - 2'd1;
  endfunction
endpackage

// File: rtl/branch_cond.sv
// RV32I branch condition evaluator; reserved func3 encodings read as not taken.
module branch_cond
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            cond
);
  always_comb begin
    cond = 1'b0;
    case (func3)
      BEQ:     cond = (srcA == srcB);
      BNE:     cond = (srcA != srcB);
      BLT:     cond = ($signed(srcA) <  $signed(srcB));
      BGE:     cond = ($signed(srcA) >= $signed(srcB));
      BLTU:    cond = (srcA <  srcB);
      BGEU:    cond = (srcA >= srcB);
      default: cond = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_predict_resolve.sv
// Direct-mapped BTB predictor for fetch plus execute-stage branch/jump resolution,
// mispredict redirect, table training and event counters.
module branch_predict_resolve
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_IDX_W = 6,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  PCF,
  output logic             PredTakenF,
  output logic [XLEN-1:0]  PredTargetF,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             JalrE,
  input  logic [2:0]       func3E,
  input  logic [XLEN-1:0]  SrcAE,
  input  logic [XLEN-1:0]  SrcBE,
  input  logic [XLEN-1:0]  PCE,
  input  logic [XLEN-1:0]  PCPlus4E,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [XLEN-1:0]  ALUResultE,
  input  logic             PredTakenE,
  input  logic [XLEN-1:0]  PredTargetE,
  input  logic             StallE,
  output logic             RedirectE,
  output logic [1:0]       PCSrcE,
  output logic [XLEN-1:0]  RedirectPCE,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MispredCnt
);
  localparam int ENTRIES = 2 ** BTB_IDX_W;
  localparam int TAG_W   = XLEN - BTB_IDX_W - 2;

  logic [ENTRIES-1:0] validTab, uncondTab;
  logic [TAG_W-1:0]   tagTab [ENTRIES];
  logic [XLEN-1:0]    tgtTab [ENTRIES];
  logic [1:0]         ctrTab [ENTRIES];

  // Fetch read
  logic [BTB_IDX_W-1:0] idxF;
  logic [TAG_W-1:0]     tagF;
  logic                 hitF;
  assign idxF        = PCF[BTB_IDX_W+1:2];
  assign tagF        = PCF[XLEN-1:BTB_IDX_W+2];
  assign hitF        = validTab[idxF] && (tagTab[idxF] == tagF);
  assign PredTakenF  = hitF && (uncondTab[idxF] || ctrTab[idxF][1]);
  assign PredTargetF = tgtTab[idxF];

  // Execute resolve
  logic                 condE, isCtrlE, takenE, validF3E, hitE, updE;
  logic [XLEN-1:0]      actTargetE;
  logic [BTB_IDX_W-1:0] idxE;
  logic [TAG_W-1:0]     tagE;

  branch_cond #(.XLEN(XLEN)) uCond (
    .func3(func3E), .srcA(SrcAE), .srcB(SrcBE), .cond(condE)
  );

  assign isCtrlE    = BranchE | JumpE | JalrE;
  assign takenE     = JumpE | JalrE | (BranchE & condE);
  assign actTargetE = JalrE ? {ALUResultE[XLEN-1:1], 1'b0} : PCTargetE;
  assign validF3E   = (func3E[2:1] != 2'b01);
  assign idxE       = PCE[BTB_IDX_W+1:2];
  assign tagE       = PCE[XLEN-1:BTB_IDX_W+2];
  assign hitE       = validTab[idxE] && (tagTab[idxE] == tagE);
  assign updE       = isCtrlE && !StallE;
  assign RedirectE  = isCtrlE &&
                      ((takenE != PredTakenE) || (takenE && (PredTargetE != actTargetE)));

  always_comb begin
    PCSrcE      = PCSRC_NONE;
    RedirectPCE = PCPlus4E;
    if (RedirectE) begin
      if (!takenE)    PCSrcE = PCSRC_PC4;
      else if (JalrE) PCSrcE = PCSRC_JALR;
      else            PCSrcE = PCSRC_TARGET;
      if (takenE) RedirectPCE = actTargetE;
    end
  end

  // Table write lands at the edge, so a same-cycle fetch read sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validTab  <= '0;
      uncondTab <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tagTab[i] <= '0;
        tgtTab[i] <= '0;
        ctrTab[i] <= WNT;
      end
    end else if (updE) begin
      if (JumpE || JalrE) begin
        validTab[idxE]  <= 1'b1;
        uncondTab[idxE] <= 1'b1;
        tagTab[idxE]    <= tagE;
        tgtTab[idxE]    <= actTargetE;
        ctrTab[idxE]    <= ST;
      end else if (hitE) begin
        if (validF3E) begin
          ctrTab[idxE] <= ctrNext(ctrTab[idxE], takenE);
          if (takenE) tgtTab[idxE] <= actTargetE;
        end
      end else if (takenE) begin
        validTab[idxE]  <= 1'b1;
        uncondTab[idxE] <= 1'b0;
        tagTab[idxE]    <= tagE;
        tgtTab[idxE]    <= actTargetE;
        ctrTab[idxE]    <= WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else if (updE) begin
      if (BranchCnt != '1) BranchCnt <= BranchCnt + CNT_W'(1);
      if (RedirectE && (MispredCnt != '1)) MispredCnt <= MispredCnt + CNT_W'(1);
    end
  end

  logic unusedBits;
  assign unusedBits = ^{PCF[1:0], PCE[1:0]};
endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: prediction, resolution, training, stall, reset.
module tb_branch_predict_resolve;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] PCF = '0;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchE, JumpE, JalrE, PredTakenE, StallE;
  logic [2:0]  func3E;
  logic [31:0] SrcAE, SrcBE, PCE, PCPlus4E, PCTargetE, ALUResultE, PredTargetE;
  logic        RedirectE;
  logic [1:0]  PCSrcE;
  logic [31:0] RedirectPCE, BranchCnt, MispredCnt;

  int total = 0, bad = 0;
  int expBr = 0, expMis = 0;

  branch_predict_resolve #(.XLEN(32), .BTB_IDX_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .func3E(func3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .PCTargetE(PCTargetE), .ALUResultE(ALUResultE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .StallE(StallE), .RedirectE(RedirectE),
    .PCSrcE(PCSrcE), .RedirectPCE(RedirectPCE), .BranchCnt(BranchCnt),
    .MispredCnt(MispredCnt)
  );

  always #5 clk = ~clk;

  task automatic clrE();
    BranchE = 0; JumpE = 0; JalrE = 0; func3E = 3'b000; StallE = 0;
    SrcAE = '0; SrcBE = '0; PCE = '0; PCPlus4E = '0; PCTargetE = '0;
    ALUResultE = '0; PredTakenE = 0; PredTargetE = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clrE(); rst = 1; PCF = 32'h100; #12;
    total++; if (PredTakenF !== 1'b0) begin bad++; $display("FAIL reset_pred got=%0d exp=0", PredTakenF); end
    total++; if (BranchCnt !== 32'd0 || MispredCnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", BranchCnt, MispredCnt); end
    total++; if (RedirectE !== 1'b0 || PCSrcE !== 2'b00) begin bad++; $display("FAIL reset_redir got=%0d/%0d exp=0/0", RedirectE, PCSrcE); end
    @(negedge clk); rst = 0; tick();
  endtask

  task automatic test_beq_taken();
    BranchE = 1; func3E = 3'b000; SrcAE = 5; SrcBE = 5; PCE = 32'h100; PCPlus4E = 32'h104;
    PCTargetE = 32'h140; PredTakenE = 0; PCF = 32'h100; #1;
    total++; if (RedirectE !== 1'b1 || PCSrcE !== 2'b01 || RedirectPCE !== 32'h140) begin bad++;
      $display("FAIL beq_redir got=%0d/%0d/%h exp=1/1/00000140", RedirectE, PCSrcE, RedirectPCE); end
    total++; if (PredTakenF !== 1'b0) begin bad++; $display("FAIL beq_war got=%0d exp=0", PredTakenF); end
    tick(); clrE(); expBr++; expMis++; #1;
    total++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h140) begin bad++;
      $display("FAIL beq_alloc got=%0d/%h exp=1/00000140", PredTakenF, PredTargetF); end
  endtask

  task automatic test_not_taken();
    BranchE = 1; func3E = 3'b000; SrcAE = 5; SrcBE = 6; PCE = 32'h100; PCPlus4E = 32'h104;
    PCTargetE = 32'h140; PredTakenE = 1; PredTargetE = 32'h140; #1;
    total++; if (RedirectE !== 1'b1 || PCSrcE !== 2'b11 || RedirectPCE !== 32'h104) begin bad++;
      $display("FAIL nt1_redir got=%0d/%0d/%h exp=1/3/00000104", RedirectE, PCSrcE, RedirectPCE); end
    tick(); expBr++; expMis++;
    PredTakenE = 0; #1;
    total++; if (PredTakenF !== 1'b0) begin bad++; $display("FAIL nt1_ctr got=%0d exp=0", PredTakenF); end
    total++; if (RedirectE !== 1'b0 || PCSrcE !== 2'b00) begin bad++;
      $display("FAIL nt2_match got=%0d/%0d exp=0/0", RedirectE, PCSrcE); end
    tick(); expBr++;
    tick(); expBr++;
    SrcBE = 5; #1;
    total++; if (RedirectE !== 1'b1 || PCSrcE !== 2'b01) begin bad++;
      $display("FAIL t4_redir got=%0d/%0d exp=1/1", RedirectE, PCSrcE); end
    tick(); expBr++; expMis++; #1;
    total++; if (PredTakenF !== 1'b0) begin bad++; $display("FAIL ctr_sat got=%0d exp=0", PredTakenF); end
    tick(); expBr++; expMis++; clrE(); #1;
    total++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h140) begin bad++;
      $display("FAIL ctr_up got=%0d/%h exp=1/00000140", PredTakenF, PredTargetF); end
  endtask

  task automatic test_func3_reserved();
    BranchE = 1; func3E = 3'b010; SrcAE = 5; SrcBE = 5; PCE = 32'h100; PCPlus4E = 32'h104;
    PCTargetE = 32'h140; PredTakenE = 1; PredTargetE = 32'h140; #1;
    total++; if (RedirectE !== 1'b1 || PCSrcE !== 2'b11) begin bad++;
      $display("FAIL f3res_redir got=%0d/%0d exp=1/3", RedirectE, PCSrcE); end
    tick(); clrE(); expBr++; expMis++; #1;
    total++; if (PredTakenF !== 1'b1) begin bad++; $display("FAIL f3res_table got=%0d exp=1", PredTakenF); end
    total++; if (BranchCnt !== expBr || MispredCnt !== expMis) begin bad++;
      $display("FAIL f3res_cnt got=%0d/%0d exp=%0d/%0d", BranchCnt, MispredCnt, expBr, expMis); end
  endtask

  task automatic test_conds();
    logic [2:0]  f3s [6];
    logic [31:0] aV [3];
    logic [31:0] bV [3];
    logic [5:0]  expT [3];
    logic        e;
    f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    aV = '{32'h1, 32'hFFFF_FFFF, 32'h5};
    bV = '{32'hFFFF_FFFF, 32'h1, 32'h5};
    expT = '{6'b011010, 6'b100110, 6'b101001};
    BranchE = 1; StallE = 1; PredTakenE = 0; PCE = 32'h180; PCTargetE = 32'h1c0; PCPlus4E = 32'h184;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 6; j++) begin
        func3E = f3s[j]; SrcAE = aV[s]; SrcBE = bV[s]; #1;
        e = expT[s][j];
        total++; if (RedirectE !== e || PCSrcE !== (e ? 2'b01 : 2'b00)) begin bad++;
          $display("FAIL cond s=%0d f3=%0d got=%0d/%0d exp=%0d", s, func3E, RedirectE, PCSrcE, e); end
      end
    end
    clrE(); tick();
  endtask

  task automatic test_jalr();
    JalrE = 1; PCE = 32'h204; PCPlus4E = 32'h208; ALUResultE = 32'h203;
    PredTakenE = 1; PredTargetE = 32'h300; #1;
    total++; if (RedirectE !== 1'b1 || PCSrcE !== 2'b10 || RedirectPCE !== 32'h202) begin bad++;
      $display("FAIL jalr_redir got=%0d/%0d/%h exp=1/2/00000202", RedirectE, PCSrcE, RedirectPCE); end
    tick(); clrE(); expBr++; expMis++; PCF = 32'h204; #1;
    total++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h202) begin bad++;
      $display("FAIL jalr_alloc got=%0d/%h exp=1/00000202", PredTakenF, PredTargetF); end
  endtask

  task automatic test_stall();
    BranchE = 1; func3E = 3'b001; SrcAE = 1; SrcBE = 2; PCE = 32'h180; PCPlus4E = 32'h184;
    PCTargetE = 32'h1c0; PredTakenE = 0; StallE = 1; PCF = 32'h180;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (BranchCnt !== expBr || PredTakenF !== 1'b0) begin bad++;
        $display("FAIL stall_hold k=%0d got=%0d/%0d exp=%0d/0", k, BranchCnt, PredTakenF, expBr); end
    end
    StallE = 0; tick(); clrE(); expBr++; expMis++; #1;
    total++; if (BranchCnt !== expBr || MispredCnt !== expMis) begin bad++;
      $display("FAIL stall_cnt got=%0d/%0d exp=%0d/%0d", BranchCnt, MispredCnt, expBr, expMis); end
    total++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h1c0) begin bad++;
      $display("FAIL stall_alloc got=%0d/%h exp=1/000001c0", PredTakenF, PredTargetF); end
  endtask

  task automatic test_same_index();
    BranchE = 1; func3E = 3'b001; SrcAE = 1; SrcBE = 1; PCE = 32'h180; PCPlus4E = 32'h184;
    PCTargetE = 32'h1c0; PredTakenE = 1; PredTargetE = 32'h1c0; PCF = 32'h180; #1;
    total++; if (PredTakenF !== 1'b1) begin bad++; $display("FAIL same_idx_old got=%0d exp=1", PredTakenF); end
    total++; if (RedirectE !== 1'b1 || PCSrcE !== 2'b11 || RedirectPCE !== 32'h184) begin bad++;
      $display("FAIL same_idx_redir got=%0d/%0d/%h exp=1/3/00000184", RedirectE, PCSrcE, RedirectPCE); end
    tick(); clrE(); expBr++; expMis++; #1;
    total++; if (PredTakenF !== 1'b0) begin bad++; $display("FAIL same_idx_new got=%0d exp=0", PredTakenF); end
  endtask

  task automatic test_alias();
    JumpE = 1; PCE = 32'h300; PCPlus4E = 32'h304; PCTargetE = 32'h400; PredTakenE = 0; #1;
    total++; if (RedirectE !== 1'b1 || PCSrcE !== 2'b01 || RedirectPCE !== 32'h400) begin bad++;
      $display("FAIL jal_redir got=%0d/%0d/%h exp=1/1/00000400", RedirectE, PCSrcE, RedirectPCE); end
    tick(); clrE(); expBr++; expMis++; PCF = 32'h100; #1;
    total++; if (PredTakenF !== 1'b0) begin bad++; $display("FAIL alias_evict got=%0d exp=0", PredTakenF); end
    PCF = 32'h300; #1;
    total++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h400) begin bad++;
      $display("FAIL alias_new got=%0d/%h exp=1/00000400", PredTakenF, PredTargetF); end
    total++; if (BranchCnt !== expBr || MispredCnt !== expMis) begin bad++;
      $display("FAIL alias_cnt got=%0d/%0d exp=%0d/%0d", BranchCnt, MispredCnt, expBr, expMis); end
  endtask

  task automatic test_reset_mid();
    #2 rst = 1; #1;
    total++; if (PredTakenF !== 1'b0) begin bad++; $display("FAIL rstmid_pred got=%0d exp=0", PredTakenF); end
    total++; if (BranchCnt !== 32'd0 || MispredCnt !== 32'd0) begin bad++;
      $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", BranchCnt, MispredCnt); end
    @(negedge clk); rst = 0; tick(); PCF = 32'h204; #1;
    total++; if (PredTakenF !== 1'b0) begin bad++; $display("FAIL rstmid_miss got=%0d exp=0", PredTakenF); end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_not_taken();
    test_func3_reserved();
    test_conds();
    test_jalr();
    test_stall();
    test_same_index();
    test_alias();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Combined fetch-stage branch predictor and execute-stage branch resolver for the pipelined RISC-V core.
- Fetch side: direct-mapped BTB with per-entry 2-bit saturating counters supplies predicted direction and target for PCF.
- Execute side: evaluates all six RV32I branch conditions from the operands, resolves JAL/JALR, detects mispredictions, drives redirect/flush, updates the table and counts events.

Parameters:
- XLEN, 32, datapath/PC width.
- BTB_IDX_W, 6, index bits; entries = 2**BTB_IDX_W.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- PCF  in  XLEN  fetch PC.
- PredTakenF  out  1  prediction for PCF.
- PredTargetF  out  XLEN  predicted target, valid when PredTakenF=1.
- BranchE, JumpE, JalrE  in  1 each  instruction class in E.
- func3E  in  3  branch function.
- SrcAE, SrcBE  in  XLEN  compare operands.
- PCE, PCPlus4E, PCTargetE, ALUResultE  in  XLEN  PC, PC+4, PC+imm, JALR sum.
- PredTakenE  in  1  PredTakenF piped to E.
- PredTargetE  in  XLEN  PredTargetF piped to E.
- StallE  in  1  E held; suppresses update and counting.
- RedirectE  out  1  mispredict; flush D and E, load RedirectPCE.
- PCSrcE  out  2  00 none, 01 PCTargetE, 10 JALR target, 11 PCPlus4E.
- RedirectPCE  out  XLEN  selected redirect PC.
- BranchCnt, MispredCnt  out  CNT_W each  resolved control-flow count, mispredict count.

Behaviour:
- Single clock clk; reset rst asynchronous, active-high.
- Reset: every entry valid=0, ctr=2'b01; BranchCnt=MispredCnt=0; all outputs combinational from this state (PredTakenF=0, RedirectE=0 with classes low).
- Entry fields: valid, tag=PC[XLEN-1:BTB_IDX_W+2], target, ctr, uncond.
- Index: PC[BTB_IDX_W+1:2].
- Fetch read is combinational, 0-cycle.
  - hit = valid && tag match.
  - PredTakenF = hit && (uncond || ctr[1]).
  - PredTargetF = entry target.
- Condition evaluation by func3E:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010/011: not taken, no table update, still counted.
- Actual outcome:
  - taken = JumpE || JalrE || (BranchE && cond).
  - Actual target: JalrE gives {ALUResultE[XLEN-1:1],1'b0}; otherwise PCTargetE.
- Mispredict (BranchE|JumpE|JalrE):
  - taken != PredTakenE, or
  - taken && PredTargetE != actual target.
- PCSrcE and RedirectPCE when RedirectE:
  - taken, JALR: 10.
  - taken, other: 01.
  - not taken: 11 (recover to PCPlus4E).
  - Otherwise PCSrcE=00; RedirectPCE=PCPlus4E (don't-care).
- Update at posedge, when (BranchE|JumpE|JalrE) && !StallE, at index from PCE:
  - Branch, tag hit: ctr saturating ++ if taken, -- if not (11 and 00 saturate); target rewritten if taken.
  - Branch, miss, taken: allocate/overwrite: valid=1, new tag, target, ctr=2'b10, uncond=0.
  - Branch, miss, not taken: no write.
  - JAL/JALR: allocate or overwrite; ctr=2'b11, uncond=1, target = actual target.
- Counters, same gating:
  - BranchCnt += 1.
  - MispredCnt += RedirectE.
  - Both saturate at all-ones.
- Same-cycle fetch read and E write to one index: fetch sees the pre-update entry (write-after-read).
- Aliasing: a different tag at the same index is evicted on allocate.
- Reset mid-operation clears the table immediately; the next fetch misses.

Decomposition:
- Shared package (riscv_pkg):
  - func3 branch constants: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - PCSrc encodings: PCSRC_NONE, PCSRC_TARGET, PCSRC_JALR, PCSRC_PC4.
  - Counter state constants: SNT, WNT, WT, ST.
- Sub-module branch_cond: combinational func3/SrcAE/SrcBE → cond. Reused by the ALU-flag-free datapath.
- Table and counters stay in the top module.

Test Plan:
- Reset, then PCF=0x100 → PredTakenF=0; counters 0. Assert rst mid-run after allocations → entries cleared asynchronously; next fetch of allocated PC misses.
- BEQ at PCE=0x100, SrcA=SrcB=5, PredTakenE=0, PCTargetE=0x140 → RedirectE=1, PCSrcE=01, RedirectPCE=0x140. Next cycle PCF=0x100 → PredTakenF=1, PredTargetF=0x140 (ctr=10).
- Same branch not taken twice → first RedirectE=1, PCSrcE=11, RedirectPCE=0x104, ctr 10→01; second PredTakenE=0 matches, no redirect, ctr→00 and saturates.
- BLTU SrcA=1, SrcB=0xFFFFFFFF → taken; BLT same operands → not taken. func3=010 → not taken, table unchanged, BranchCnt still increments.
- JALR, ALUResultE=0x203, PredTakenE=1, PredTargetE=0x300 → target mismatch: RedirectE=1, PCSrcE=10, RedirectPCE=0x202; entry target becomes 0x202, uncond=1.
- Resolved branch with StallE=1 held 3 cycles → no table change, BranchCnt increments once only after release. Same-index read/write cycle → PredTakenF reflects the old entry.
